// File: rtl/gain_divider.sv
// rtl/gain_divider.sv - two-channel sample-rate signed divider, signal*2^W/gain, one shared restoring datapath
module gain_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_clk,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    output logic [W-1:0] sample_out0,
    output logic [W-1:0] sample_out1,
    output logic [W-1:0] sample_out2,
    output logic [W-1:0] sample_out3,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_STORE} state_t;

    state_t        state_q, state_d;
    logic          ch_q, ch_d;
    logic          sc_prev_q;
    logic [W-1:0]  g0_q, s0_q, g1_q, s1_q;
    logic          neg_q, sat_q, zero_q;
    logic [W:0]    absg_q;
    logic [W+1:0]  rem_q;
    logic [W-1:0]  q_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  res0_q;
    logic [W-1:0]  out0_q, out1_q, out2_q, out3_q;

    logic          start;
    logic [W-1:0]  sel_g, sel_s;
    logic [W:0]    ext_g, ext_s, abs_g, abs_s;
    logic          sat_c, zero_c, neg_c;
    logic [W+1:0]  rem_sh, rem_nx;
    logic          ge;
    logic [W-1:0]  res_c;

    assign start = sample_clk & ~sc_prev_q & (state_q == S_IDLE);

    // Operand selection and magnitudes; W+1 bits keep |-2^(W-1)| representable.
    assign sel_g  = ch_q ? g1_q : g0_q;
    assign sel_s  = ch_q ? s1_q : s0_q;
    assign ext_g  = {sel_g[W-1], sel_g};
    assign ext_s  = {sel_s[W-1], sel_s};
    assign abs_g  = sel_g[W-1] ? ((W+1)'(0) - ext_g) : ext_g;
    assign abs_s  = sel_s[W-1] ? ((W+1)'(0) - ext_s) : ext_s;
    assign neg_c  = sel_g[W-1] ^ sel_s[W-1];
    assign zero_c = (sel_s == '0);
    assign sat_c  = ((sel_g == '0) && !zero_c) || ({abs_s, 1'b0} >= {1'b0, abs_g});

    // One restoring-division step per DIV cycle.
    assign rem_sh = rem_q << 1;
    assign ge     = (rem_sh >= {1'b0, absg_q});
    assign rem_nx = ge ? (rem_sh - {1'b0, absg_q}) : rem_sh;

    always_comb begin
        res_c = '0;
        if (zero_q) begin
            res_c = '0;
        end else if (sat_q) begin
            res_c = neg_q ? (W'(0) - MAX_POS) : MAX_POS;
        end else begin
            res_c = neg_q ? (W'(0) - q_q) : q_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ch_d    = 1'b0;
                end
            end
            S_LOAD: state_d = S_DIV;
            S_DIV: begin
                if (cnt_q == CW'(W-1)) state_d = S_STORE;
            end
            S_STORE: begin
                if (!ch_q) begin
                    state_d = S_LOAD;
                    ch_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= 1'b0;
            sc_prev_q <= 1'b0;
            g0_q      <= '0;
            s0_q      <= '0;
            g1_q      <= '0;
            s1_q      <= '0;
            neg_q     <= 1'b0;
            sat_q     <= 1'b0;
            zero_q    <= 1'b0;
            absg_q    <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            res0_q    <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            out3_q    <= '0;
        end else begin
            sc_prev_q <= sample_clk;
            state_q   <= state_d;
            ch_q      <= ch_d;
            if (start) begin
                g0_q <= sample_in0;
                s0_q <= sample_in1;
                g1_q <= sample_in2;
                s1_q <= sample_in3;
            end
            case (state_q)
                S_LOAD: begin
                    neg_q  <= neg_c;
                    sat_q  <= sat_c;
                    zero_q <= zero_c;
                    absg_q <= abs_g;
                    rem_q  <= {1'b0, abs_s};
                    q_q    <= '0;
                    cnt_q  <= '0;
                end
                S_DIV: begin
                    rem_q <= rem_nx;
                    q_q   <= {q_q[W-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                S_STORE: begin
                    // All four outputs publish together once channel 1 is done.
                    if (ch_q) begin
                        out0_q <= g0_q;
                        out1_q <= res0_q;
                        out2_q <= g1_q;
                        out3_q <= res_c;
                    end else begin
                        res0_q <= res_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_out0 = out0_q;
    assign sample_out1 = out1_q;
    assign sample_out2 = out2_q;
    assign sample_out3 = out3_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_gain_divider.sv
// tb/tb_gain_divider.sv - directed self-checking bench for gain_divider
module tb_gain_divider;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_clk = 1'b0;
    logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [15:0]        out0, out1, out2, out3;
    logic               busy;

    int total = 0;
    int bad = 0;

    gain_divider #(.W(16)) dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk),
        .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
        .sample_out0(out0), .sample_out1(out1), .sample_out2(out2), .sample_out3(out3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent arithmetic reference: trunc(s*65536/g) with symmetric saturation.
    function automatic logic [15:0] ref_div(input int g, input int s);
        longint as, ag, r;
        bit neg;
        as  = (s < 0) ? -s : s;
        ag  = (g < 0) ? -g : g;
        neg = (s < 0) ^ (g < 0);
        if (s == 0) return 16'd0;
        if (g == 0 || 2 * as >= ag) return neg ? 16'h8001 : 16'h7fff;
        r = (longint'(s) * 65536) / longint'(g);
        return 16'(r);
    endfunction

    // Launches one conversion and returns the cycle count until busy falls (0 on timeout).
    task automatic do_conv(input int g0, input int s0, input int g1, input int s1, output int cycles);
        int k;
        in0 = 16'(g0); in1 = 16'(s0); in2 = 16'(g1); in3 = 16'(s1);
        sample_clk = 1'b1;
        k = 0;
        cycles = 0;
        do begin
            tick();
            k++;
        end while (busy && k < 100);
        if (!busy) cycles = k;
        sample_clk = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_clk = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if ({out0, out1, out2, out3} !== 64'd0) begin bad++; $display("FAIL reset_outs got=%h want=0", {out0, out1, out2, out3}); end
        repeat (3) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_start_at_release();
        int k;
        rst = 1'b1;
        in0 = 16'sd16384; in1 = 16'sd8000; in2 = 16'sd16384; in3 = -16'sd8000;
        sample_clk = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL release_start_busy got=%0b want=1", busy); end
        k = 1;
        while (busy && k < 100) begin tick(); k++; end
        total++; if (k !== 37) begin bad++; $display("FAIL release_latency got=%0d want=37", k); end
        total++; if (out1 !== 16'd32000) begin bad++; $display("FAIL release_out1 got=%0d want=32000", $signed(out1)); end
        total++; if (out3 !== 16'(-32000)) begin bad++; $display("FAIL release_out3 got=%0d want=-32000", $signed(out3)); end
        sample_clk = 1'b0;
        tick();
    endtask

    task automatic test_timing();
        int busy_cnt;
        in0 = 16'sd16384; in1 = 16'sd4096; in2 = 16'sd16384; in3 = -16'sd4096;
        sample_clk = 1'b1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (k == 36) begin
                total++; if (out1 !== 16'd32000) begin bad++; $display("FAIL timing_hold_e36 got=%0d want=32000", $signed(out1)); end
            end
            if (k == 37) begin
                total++; if (out1 !== 16'd16384) begin bad++; $display("FAIL timing_out1 got=%0d want=16384", $signed(out1)); end
                total++; if (out3 !== 16'(-16384)) begin bad++; $display("FAIL timing_out3 got=%0d want=-16384", $signed(out3)); end
                total++; if (out0 !== 16'd16384 || out2 !== 16'd16384) begin bad++; $display("FAIL timing_gains got=%0d,%0d want=16384,16384", $signed(out0), $signed(out2)); end
            end
        end
        total++; if (busy_cnt !== 36) begin bad++; $display("FAIL timing_busy_len got=%0d want=36", busy_cnt); end
        sample_clk = 1'b0;
        tick();
    endtask

    task automatic test_polarity();
        int c;
        do_conv(-16384, 4096, 3, 1, c);
        total++; if (c !== 37) begin bad++; $display("FAIL pol_a_latency got=%0d want=37", c); end
        total++; if (out1 !== 16'(-16384)) begin bad++; $display("FAIL pol_neg_gain got=%0d want=-16384", $signed(out1)); end
        total++; if (out3 !== 16'd21845) begin bad++; $display("FAIL pol_third got=%0d want=21845", $signed(out3)); end
        total++; if (out0 !== 16'(-16384)) begin bad++; $display("FAIL pol_out0 got=%0d want=-16384", $signed(out0)); end
        do_conv(3, -1, -3, -1, c);
        total++; if (out1 !== 16'(-21845)) begin bad++; $display("FAIL pol_neg_third got=%0d want=-21845", $signed(out1)); end
        total++; if (out3 !== 16'd21845) begin bad++; $display("FAIL pol_double_neg got=%0d want=21845", $signed(out3)); end
    endtask

    task automatic test_saturation();
        int c;
        do_conv(16384, 8192, 0, 100, c);
        total++; if (out1 !== 16'd32767) begin bad++; $display("FAIL sat_boundary got=%0d want=32767", $signed(out1)); end
        total++; if (out3 !== 16'd32767) begin bad++; $display("FAIL sat_div0_pos got=%0d want=32767", $signed(out3)); end
        do_conv(0, -100, 0, 0, c);
        total++; if (out1 !== 16'(-32767)) begin bad++; $display("FAIL sat_div0_neg got=%0d want=-32767", $signed(out1)); end
        total++; if (out3 !== 16'd0) begin bad++; $display("FAIL sat_zero_zero got=%0d want=0", $signed(out3)); end
        do_conv(16384, -32768, -5, -32768, c);
        total++; if (out1 !== 16'(-32767)) begin bad++; $display("FAIL sat_min_sig got=%0d want=-32767", $signed(out1)); end
        total++; if (out3 !== 16'd32767) begin bad++; $display("FAIL sat_min_sig_neg_gain got=%0d want=32767", $signed(out3)); end
        do_conv(16384, 8191, 32767, 0, c);
        total++; if (out1 !== 16'd32764) begin bad++; $display("FAIL sat_just_below got=%0d want=32764", $signed(out1)); end
        total++; if (out3 !== 16'd0) begin bad++; $display("FAIL zero_sig got=%0d want=0", $signed(out3)); end
    endtask

    task automatic test_roundtrip();
        int c, g, s, v, err, tol;
        do_conv(16384, 3000, -16384, -3000, c);
        total++; if (out1 !== 16'd12000) begin bad++; $display("FAIL rt_fixed got=%0d want=12000", $signed(out1)); end
        total++; if (out3 !== 16'd12000) begin bad++; $display("FAIL rt_fixed_neg got=%0d want=12000", $signed(out3)); end
        for (int i = 0; i < 10; i++) begin
            g = int'($urandom_range(256, 32767));
            if ($urandom_range(0, 1) == 1) g = -g;
            s = int'($urandom_range(0, 60000)) - 30000;
            v = int'((longint'(s) * longint'(g)) / 65536);
            do_conv(g, v, g, s / 8, c);
            total++; if (out1 !== ref_div(g, v)) begin bad++; $display("FAIL rt_model g=%0d v=%0d got=%0d want=%0d", g, v, $signed(out1), $signed(ref_div(g, v))); end
            total++; if (out3 !== ref_div(g, s / 8)) begin bad++; $display("FAIL rt_model3 g=%0d s=%0d got=%0d want=%0d", g, s / 8, $signed(out3), $signed(ref_div(g, s / 8))); end
            err = int'($signed(out1)) - s;
            if (err < 0) err = -err;
            tol = 65536 / ((g < 0) ? -g : g) + 1;
            total++; if (err > tol) begin bad++; $display("FAIL rt_bound g=%0d s=%0d got=%0d err=%0d tol=%0d", g, s, $signed(out1), err, tol); end
        end
    endtask

    task automatic test_extra_edge();
        logic [15:0] prev1;
        prev1 = out1;
        in0 = 16'sd3; in1 = 16'sd1; in2 = 16'sd16384; in3 = 16'sd2048;
        sample_clk = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 5) sample_clk = 1'b0;
            if (k == 10) sample_clk = 1'b1;
            if (k == 36) begin
                total++; if (out1 !== prev1 || busy !== 1'b1) begin bad++; $display("FAIL extra_hold got=%0d/%0b want=%0d/1", $signed(out1), busy, $signed(prev1)); end
            end
            if (k == 37) begin
                total++; if (out1 !== 16'd21845 || out3 !== 16'd8192) begin bad++; $display("FAIL extra_update got=%0d,%0d want=21845,8192", $signed(out1), $signed(out3)); end
            end
            if (k == 45) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL extra_not_queued got=%0b want=0", busy); end
            end
        end
        sample_clk = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        int c;
        in0 = 16'sd16384; in1 = 16'sd1000; in2 = 16'sd16384; in3 = 16'sd1000;
        sample_clk = 1'b1;
        for (int k = 1; k <= 20; k++) tick();
        rst = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
        total++; if ({out0, out1, out2, out3} !== 64'd0) begin bad++; $display("FAIL midrst_outs got=%h want=0", {out0, out1, out2, out3}); end
        rst = 1'b0;
        sample_clk = 1'b0;
        tick();
        do_conv(-8192, 1000, 4096, -500, c);
        total++; if (c !== 37) begin bad++; $display("FAIL midrst_latency got=%0d want=37", c); end
        total++; if (out1 !== 16'(-8000) || out3 !== 16'(-8000)) begin bad++; $display("FAIL midrst_results got=%0d,%0d want=-8000,-8000", $signed(out1), $signed(out3)); end
    endtask

    initial begin
        test_reset();
        test_start_at_release();
        test_timing();
        test_polarity();
        test_saturation();
        test_roundtrip();
        test_extra_edge();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
